gpio_eic: RTL
=============

# gpio_eic

GPIO external interrupt controller, directly downstream of the GPIO block. It consumes the 16 single-cycle edge pulses the GPIO block produces for GPIO[31:16] and latches them into pending bits. It masks them, picks the highest-priority source and raises one request to the core through a request/acknowledge/end-of-interrupt handshake. Software accesses it through the same 8-bit-offset peripheral bus used by the other sysio blocks.

## Interface
- No parameters; 16 sources, 32-bit bus, 8-bit offsets are fixed.
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high; clears all state
- waddr_i  input  8  write offset
- data_i  input  32  write data
- sel_i  input  4  write byte enables, bit k gates data_i[8k+7:8k]
- we_i  input  1  write strobe, one access per asserted cycle
- raddr_i  input  8  read offset
- rd_i  input  1  read strobe
- data_o  output  32  registered read data
- gpio_trap_irq_i  input  16  edge pulses from GPIO block, bit i = GPIO(16+i), 1-cycle pulses, may be simultaneous
- irq_o  output  1  interrupt request to core
- irq_id_o  output  4  source index of the current request, valid while irq_o=1
- irq_ack_i  input  1  core took the trap; sampled only in REQ

## Operation
- Registers:
  - EIC_PND 0x00: RW1C; bits [15:0] pending, rest read 0.
  - EIC_ENA 0x04: RW; [15:0] source enables, [31] global enable, others read 0.
  - EIC_STA 0x08: RO; [1:0] state (0 IDLE, 1 REQ, 2 ACTIVE), [7:4] latched id.
  - EIC_EOI 0x0C: WO, reads 0; data_i[3:0] = id being completed.
  - Any other offset: writes ignored, reads 0.
- Pending bit i:
  - Set when gpio_trap_irq_i[i]=1, regardless of enables.
  - Cleared by a PND write with a 1 in that bit (byte lane enabled), or by irq_ack_i accepted for id i.
  - Set has priority over any same-cycle clear.
- Eligible vector = PND & ENA[15:0] & {16{ENA[31]}}. Lowest index has highest priority.
- FSM:
  - IDLE: irq_o=0. If eligible≠0, latch id = lowest set index and go to REQ.
  - REQ: irq_o=1, irq_id_o=id.
    - If irq_ack_i=1, clear PND[id] and go to ACTIVE.
    - Else if PND[id]&ENA[id]&ENA[31]==0 (masked or software-cleared), go to IDLE; the request is withdrawn.
    - The ack check takes precedence over withdrawal.
    - A higher-priority source arriving while in REQ does not preempt.
  - ACTIVE: irq_o=0; id held. An EOI write with data_i[3:0]==id (sel_i[0]=1) goes to IDLE. A mismatched EOI is ignored.
  - irq_ack_i outside REQ is ignored.
- Non-nesting: no new request while in ACTIVE, though pending bits keep accumulating.

## Timing
- Reset values: data_o=0, irq_o=0, irq_id_o=0, PND=0, ENA=0, state IDLE, id=0.
- Writes take effect at the clock edge of the we_i cycle.
- Reads: data_o updates at the edge of the rd_i cycle and is valid the next cycle. It holds its value when rd_i=0. It reflects register state before any same-cycle write.
- Pulse latency: a pulse in cycle N sets PND at the end of N, the FSM enters REQ at the end of N+1, and irq_o=1 during N+2.
- Ack in cycle M: irq_o=0 and PND[id]=0 from M+1.
- EOI in cycle E: IDLE at E+1. If another source is eligible, irq_o=1 again at E+2.
- irq_o and irq_id_o are registered state decodes, with no combinational path from any input.
- Reset asserted mid-handshake: state returns to IDLE immediately (async) and irq_o drops without waiting for a clock.

## Test plan
- Reset and enable: assert rst during REQ → irq_o=0 with no clock edge; all registers read 0 after release.
- Single source, full handshake:
  - Set ENA=0x8000_0001; pulse bit 0 in cycle N → irq_o=1, irq_id_o=0 at N+2.
  - Ack → PND reads 0x0, STA=0x2.
  - EOI 0x0 → STA=0x0.
- Priority and queueing:
  - Set ENA=0x8000_FFFF; pulse bits 5 and 3 in the same cycle → irq_id_o=3.
  - Ack, then EOI 3 → second request appears 2 cycles later with irq_id_o=5.
- Masking:
  - ENA[31]=0; pulse bit 2 → PND=0x4, irq_o stays 0.
  - Set ENA=0x8000_0004 → irq_o=1 two cycles later.
  - In REQ, write ENA=0 → irq_o=0 next cycle and STA=0.
- Simultaneous set/clear: pulse bit 7 in the same cycle as a PND write of 0x80 → PND reads 0x80. Pulse the acked id in the ack cycle → PND bit remains set.
- EOI mismatch and ack outside REQ:
  - In ACTIVE with id 4, write EOI 0x5 → STA stays 0x42.
  - irq_ack_i pulses in IDLE have no effect on PND.

Source files
------------

// File: rtl/gpio_eic.sv
// gpio_eic: external interrupt controller for GPIO[31:16] edge pulses.
// Latches edge pulses into pending bits, masks them, and offers the
// lowest-index eligible source to the core via a request / acknowledge /
// end-of-interrupt handshake. Software sees four bus registers.

module gpio_eic (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic [7:0]  raddr_i,
    input  logic        rd_i,
    output logic [31:0] data_o,
    input  logic [15:0] gpio_trap_irq_i,
    output logic        irq_o,
    output logic [3:0]  irq_id_o,
    input  logic        irq_ack_i
);

    // Register offsets
    localparam logic [7:0]  ADDR_PND = 8'h00;
    localparam logic [7:0]  ADDR_ENA = 8'h04;
    localparam logic [7:0]  ADDR_STA = 8'h08;
    localparam logic [7:0]  ADDR_EOI = 8'h0C;

    // Implemented bits of the enable register: source enables plus global enable
    localparam logic [31:0] ENA_MASK = 32'h8000_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Lowest set index of a 16-bit vector (0 when the vector is empty)
    function automatic logic [3:0] lowest_idx(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[3:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot decode of a source index
    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  id_q, id_d;
    logic [15:0] pnd_q, pnd_d;
    logic [31:0] ena_q, ena_d;
    logic        irq_q;
    logic [31:0] data_q;

    logic [31:0] lane_mask_s;
    logic        wr_pnd_s;
    logic        wr_ena_s;
    logic        eoi_match_s;
    logic [15:0] pnd_clr_s;
    logic [15:0] ack_clr_s;
    logic [15:0] ena_src_s;
    logic [15:0] eligible_s;
    logic        req_live_s;
    logic [31:0] rdata_s;

    assign lane_mask_s = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
    assign wr_pnd_s    = we_i && (waddr_i == ADDR_PND);
    assign wr_ena_s    = we_i && (waddr_i == ADDR_ENA);
    assign eoi_match_s = we_i && (waddr_i == ADDR_EOI) && sel_i[0] && (data_i[3:0] == id_q);

    assign ena_src_s   = ena_q[15:0];
    assign eligible_s  = pnd_q & ena_src_s & {16{ena_q[31]}};
    // The latched request stays valid only while its source is pending and unmasked
    assign req_live_s  = pnd_q[id_q] & ena_src_s[id_q] & ena_q[31];

    // Pending next state: clears from software or accepted ack, new pulses win
    always_comb begin
        pnd_clr_s = 16'd0;
        ack_clr_s = 16'd0;
        if (wr_pnd_s) begin
            pnd_clr_s = data_i[15:0] & lane_mask_s[15:0];
        end else begin
            pnd_clr_s = 16'd0;
        end
        if ((state_q == ST_REQ) && irq_ack_i) begin
            ack_clr_s = onehot16(id_q);
        end else begin
            ack_clr_s = 16'd0;
        end
        pnd_d = (pnd_q & ~(pnd_clr_s | ack_clr_s)) | gpio_trap_irq_i;
    end

    // Enable next state: byte-lane merge of the write data, unimplemented bits kept 0
    always_comb begin
        ena_d = ena_q;
        if (wr_ena_s) begin
            ena_d = ((ena_q & ~lane_mask_s) | (data_i & lane_mask_s)) & ENA_MASK;
        end else begin
            ena_d = ena_q;
        end
    end

    // Handshake FSM next state and latched source id
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (eligible_s != 16'd0) begin
                    state_d = ST_REQ;
                    id_d    = lowest_idx(eligible_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Ack is checked first so a same-cycle mask cannot lose a taken trap
                if (irq_ack_i) begin
                    state_d = ST_ACTIVE;
                end else if (!req_live_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_ACTIVE: begin
                if (eoi_match_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                id_d    = 4'd0;
            end
        endcase
    end

    // Read mux over the pre-write register state
    always_comb begin
        rdata_s = 32'd0;
        case (raddr_i)
            ADDR_PND: rdata_s = {16'd0, pnd_q};
            ADDR_ENA: rdata_s = ena_q;
            ADDR_STA: rdata_s = {24'd0, id_q, 2'b00, state_q};
            default:  rdata_s = 32'd0;
        endcase
    end

    // Control and status state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= 4'd0;
            pnd_q   <= 16'd0;
            ena_q   <= 32'd0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            pnd_q   <= pnd_d;
            ena_q   <= ena_d;
            irq_q   <= (state_d == ST_REQ);
        end
    end

    // Read data register, holds when no read is strobed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= 32'd0;
        end else if (rd_i) begin
            data_q <= rdata_s;
        end else begin
            data_q <= data_q;
        end
    end

    assign data_o   = data_q;
    assign irq_o    = irq_q;
    assign irq_id_o = id_q;

endmodule
